mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (instruction/data side), the
// arbiter and the shared memory port.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        i_done;
  logic        d_done;
  logic [15:0] i_rdata;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_done, d_done, i_rdata, d_rdata, mem_en, mem_wr, mem_addr,
           mem_wdata, busy, i_grant_cnt, d_grant_cnt
  );

  // Requester + memory view
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_done, d_done, i_rdata, d_rdata, mem_en, mem_wr, mem_addr,
           mem_wdata, busy, i_grant_cnt, d_grant_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) memory arbiter with alternating priority on
// contention and a fixed LATENCY-cycle memory access.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  accessCnt;
  logic        ownerD;
  logic        lastD;
  logic        memEn;
  logic        memWr;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        iDone;
  logic        dDone;
  logic [15:0] iRdata;
  logic [15:0] dRdata;
  logic        busy;
  logic [15:0] iGrantCnt;
  logic [15:0] dGrantCnt;
  logic        grantD;

  // D wins a tie unless it won the previous grant, so neither side starves
  assign grantD = bus.d_req && (!bus.i_req || !lastD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      accessCnt <= '0;
      ownerD    <= 1'b0;
      lastD     <= 1'b0;
      memEn     <= 1'b0;
      memWr     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      iDone     <= 1'b0;
      dDone     <= 1'b0;
      iRdata    <= '0;
      dRdata    <= '0;
      busy      <= 1'b0;
      iGrantCnt <= '0;
      dGrantCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            ownerD    <= grantD;
            lastD     <= grantD;
            memAddr   <= grantD ? bus.d_addr : bus.i_addr;
            memWr     <= grantD && bus.d_wr;
            memWdata  <= grantD ? bus.d_wdata : 16'h0000;
            memEn     <= 1'b1;
            busy      <= 1'b1;
            accessCnt <= '0;
            state     <= ACCESS;
            if (grantD) begin
              if (dGrantCnt != 16'hFFFF) dGrantCnt <= dGrantCnt + 16'd1;
            end else begin
              if (iGrantCnt != 16'hFFFF) iGrantCnt <= iGrantCnt + 16'd1;
            end
          end
        end
        ACCESS: begin
          memEn <= 1'b0;
          if (accessCnt == LAST_CNT) begin
            // mem_rdata is only valid in this final access cycle
            if (!memWr) begin
              if (ownerD) dRdata <= bus.mem_rdata;
              else        iRdata <= bus.mem_rdata;
            end
            memWr <= 1'b0;
            dDone <= ownerD;
            iDone <= !ownerD;
            state <= RESP;
          end else begin
            accessCnt <= accessCnt + 4'd1;
          end
        end
        RESP: begin
          iDone <= 1'b0;
          dDone <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en      = memEn;
  assign bus.mem_wr      = memWr;
  assign bus.mem_addr    = memAddr;
  assign bus.mem_wdata   = memWdata;
  assign bus.i_done      = iDone;
  assign bus.d_done      = dDone;
  assign bus.i_rdata     = iRdata;
  assign bus.d_rdata     = dRdata;
  assign bus.busy        = busy;
  assign bus.i_grant_cnt = iGrantCnt;
  assign bus.d_grant_cnt = dGrantCnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written contention, reset-abort and counter-saturation sequences.
module tb_mem_arbiter;

  typedef struct {
    logic        iReq;
    logic        dReq;
    logic        dWr;
    logic [15:0] iAddr;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    logic [15:0] memRdata;
    logic        expD;
    logic [15:0] expAddr;
    logic        expWr;
    logic [15:0] expIRdata;
    logic [15:0] expDRdata;
  } vec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] expICnt = 16'h0000;
  logic [15:0] expDCnt = 16'h0000;
  vec_t vecs [10];
  vec_t extraVec;

  mem_arbiter_if bif ();

  mem_arbiter #(.LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction from IDLE, checked cycle by cycle against LATENCY=4
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    bif.i_req     = v.iReq;
    bif.d_req     = v.dReq;
    bif.d_wr      = v.dWr;
    bif.i_addr    = v.iAddr;
    bif.d_addr    = v.dAddr;
    bif.d_wdata   = v.dWdata;
    bif.mem_rdata = ~v.memRdata;
    if (v.expD) begin
      if (expDCnt != 16'hFFFF) expDCnt++;
    end else begin
      if (expICnt != 16'hFFFF) expICnt++;
    end
    @(negedge clk);
    checkOutput({tag, " mem_en"}, 16'(bif.mem_en), 16'h1);
    checkOutput({tag, " busy"}, 16'(bif.busy), 16'h1);
    checkOutput({tag, " mem_addr"}, bif.mem_addr, v.expAddr);
    checkOutput({tag, " mem_wr"}, 16'(bif.mem_wr), 16'(v.expWr));
    if (v.expWr) checkOutput({tag, " mem_wdata"}, bif.mem_wdata, v.dWdata);
    bif.i_req = 1'b0;
    bif.d_req = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s mem_en c%0d", tag, k), 16'(bif.mem_en), 16'h0);
      checkOutput($sformatf("%s addr hold c%0d", tag, k), bif.mem_addr, v.expAddr);
      checkOutput($sformatf("%s early done c%0d", tag, k), 16'({bif.i_done, bif.d_done}), 16'h0);
      if (k == 4) bif.mem_rdata = v.memRdata;
    end
    @(negedge clk);
    checkOutput({tag, " i_done"}, 16'(bif.i_done), 16'(!v.expD));
    checkOutput({tag, " d_done"}, 16'(bif.d_done), 16'(v.expD));
    checkOutput({tag, " i_rdata"}, bif.i_rdata, v.expIRdata);
    checkOutput({tag, " d_rdata"}, bif.d_rdata, v.expDRdata);
    checkOutput({tag, " i_grant_cnt"}, bif.i_grant_cnt, expICnt);
    checkOutput({tag, " d_grant_cnt"}, bif.d_grant_cnt, expDCnt);
    @(negedge clk);
    checkOutput({tag, " done clear"}, 16'({bif.i_done, bif.d_done}), 16'h0);
    checkOutput({tag, " busy clear"}, 16'(bif.busy), 16'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem_en"}, 16'(bif.mem_en), 16'h0);
    checkOutput({tag, " mem_wr"}, 16'(bif.mem_wr), 16'h0);
    checkOutput({tag, " mem_addr"}, bif.mem_addr, 16'h0);
    checkOutput({tag, " mem_wdata"}, bif.mem_wdata, 16'h0);
    checkOutput({tag, " busy"}, 16'(bif.busy), 16'h0);
    checkOutput({tag, " dones"}, 16'({bif.i_done, bif.d_done}), 16'h0);
    checkOutput({tag, " i_rdata"}, bif.i_rdata, 16'h0);
    checkOutput({tag, " d_rdata"}, bif.d_rdata, 16'h0);
    checkOutput({tag, " i_grant_cnt"}, bif.i_grant_cnt, 16'h0);
    checkOutput({tag, " d_grant_cnt"}, bif.d_grant_cnt, 16'h0);
  endtask

  initial begin
    int cnt;
    logic expSideD;

    // iReq dReq dWr iAddr dAddr dWdata memRdata expD expAddr expWr expIR expDR
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 16'hBEEF, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'h1111, 1'b0, 16'h1000, 1'b0, 16'h1111, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0100, 16'h1234, 16'h5A5A, 1'b1, 16'h0100, 1'b1, 16'h1111, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h2000, 16'h2F00, 16'h0000, 16'h2222, 1'b0, 16'h2000, 1'b0, 16'h2222, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h3F00, 16'h3000, 16'h0000, 16'h3333, 1'b1, 16'h3000, 1'b0, 16'h2222, 16'h3333};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h5000, 16'h0000, 16'h5555, 1'b1, 16'h5000, 1'b0, 16'h2222, 16'h5555};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h4444, 1'b0, 16'h4000, 1'b0, 16'h4444, 16'h5555};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h4100, 16'h0000, 16'h0000, 16'h4545, 1'b0, 16'h4100, 1'b0, 16'h4545, 16'h5555};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 16'h6F00, 16'h0200, 16'hABCD, 16'h9999, 1'b1, 16'h0200, 1'b1, 16'h4545, 16'h5555};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 16'h6000, 16'h0300, 16'hFFFF, 16'h6666, 1'b0, 16'h6000, 1'b0, 16'h6666, 16'h5555};

    rst = 1'b1;
    bif.i_req = 1'b0;  bif.d_req = 1'b0;  bif.d_wr = 1'b0;
    bif.i_addr = '0;   bif.d_addr = '0;   bif.d_wdata = '0;  bif.mem_rdata = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Continuous contention from reset: D,I,D,I with done every 6 cycles
    @(negedge clk);
    rst = 1'b1;
    bif.i_req = 1'b1;  bif.d_req = 1'b1;  bif.d_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!(bif.i_done || bif.d_done) && cnt < 20);
      expSideD = (n % 2 == 0);
      if (n == 3) begin
        bif.i_req = 1'b0;
        bif.d_req = 1'b0;
      end
      checkOutput($sformatf("alt%0d interval", n), 16'(cnt), (n == 0) ? 16'd5 : 16'd6);
      checkOutput($sformatf("alt%0d d_done", n), 16'(bif.d_done), 16'(expSideD));
      checkOutput($sformatf("alt%0d i_done", n), 16'(bif.i_done), 16'(!expSideD));
    end
    checkOutput("alt i_grant_cnt", bif.i_grant_cnt, 16'd2);
    checkOutput("alt d_grant_cnt", bif.d_grant_cnt, 16'd2);
    @(negedge clk);

    // Reset during the third ACCESS cycle of an I read
    @(negedge clk);
    bif.i_req = 1'b1;  bif.i_addr = 16'h7000;  bif.mem_rdata = 16'h7777;
    repeat (3) @(negedge clk);
    checkOutput("abort pre busy", 16'(bif.busy), 16'h1);
    rst = 1'b1;
    bif.i_req = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    rst = 1'b0;
    expICnt = 16'h0000;
    expDCnt = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort idle i_done %0d", k), 16'(bif.i_done), 16'h0);
      checkOutput($sformatf("abort idle mem_en %0d", k), 16'(bif.mem_en), 16'h0);
    end
    extraVec = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0800, 16'h0000, 16'h8888, 1'b1, 16'h0800, 1'b0, 16'h0000, 16'h8888};
    applyStimulus(extraVec, "postabort");

    // Grant counter saturation
    @(negedge clk);
    force dut.iGrantCnt = 16'hFFFF;
    @(negedge clk);
    release dut.iGrantCnt;
    expICnt = 16'hFFFF;
    extraVec = '{1'b1, 1'b0, 1'b0, 16'h0900, 16'h0000, 16'h0000, 16'h9090, 1'b0, 16'h0900, 1'b0, 16'h9090, 16'h8888};
    applyStimulus(extraVec, "saturate");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // The two done pulses must never coincide
  always @(negedge clk) begin
    if (!rst && bif.i_done && bif.d_done) begin
      total++;
      bad++;
      $display("[TB] FAIL both_done: got i_done=1 d_done=1 expected at most one");
    end
  end

endmodule
